serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: W, default 32, operand width in bits, legal range 2..64.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: in_valid  input  1  operand pair valid.
REQ-006 Port: in_ready  output  1  block can accept an operand pair.
REQ-007 Port: in_a  input  W  first operand, unsigned.
REQ-008 Port: in_b  input  W  second operand, unsigned.
REQ-009 Port: in_sub  input  1  1 = compute in_a - in_b; present only with SERIAL_SUB_EN.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: out_sum  output  W  result, modulo 2^W.
REQ-013 Port: out_carry  output  1  carry out of bit W-1; in subtract mode, 1 = no borrow (in_a >= in_b).

Function
REQ-014 The block SHALL use exactly one instance of the team's 1-bit full-adder cell as its only arithmetic element, reused once per bit.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE. out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, in_valid=1 at a clock edge SHALL load in_a and in_b into shift registers, set the carry flop to 0 (add) or 1 (subtract), clear the bit counter and move to RUN.
REQ-018 In RUN, each cycle SHALL feed operand bit i (LSB first) and the carry flop into the full adder. The sum bit SHALL shift into the result register from the MSB end. The adder carry SHALL update the carry flop. The counter SHALL increment.
REQ-019 In subtract mode, the b bit SHALL be inverted before it enters the full adder.
REQ-020 After the edge that processes bit W-1, the FSM SHALL enter DONE. out_valid therefore rises W edges after the accepting edge.
REQ-021 The bit counter SHALL be ceil(log2(W)) bits wide and SHALL NOT wrap during RUN.
REQ-022 In DONE, out_sum and out_carry SHALL hold stable until out_ready=1 at an edge; the FSM then returns to IDLE.
REQ-023 While in DONE, a new in_valid SHALL be ignored, because in_ready=0. There is no overlap between operations.
REQ-024 in_a, in_b and in_sub SHALL be sampled only at the accepting edge; later changes to them SHALL have no effect.
REQ-025 Throughput SHALL be one operation per W+2 cycles minimum: one accept edge, W run edges and one drain edge with out_ready=1.

Reset
REQ-026 On reset assertion, the FSM SHALL go to IDLE immediately, regardless of clock, including mid-RUN or in DONE.
REQ-027 Reset values: in_ready=1 after deassertion, out_valid=0, out_sum=0, out_carry=0. The carry flop, counter and shift registers SHALL be 0.
REQ-028 An operation aborted by reset SHALL produce no output; the first handshake after reset SHALL start a fresh operation.

Configuration
REQ-029 Macro SERIAL_SUB_EN: when defined, the in_sub port and subtract mode (REQ-017, REQ-019) SHALL exist.
REQ-030 When SERIAL_SUB_EN is undefined, in_sub SHALL be absent and the block SHALL perform addition only, with the carry always initialised to 0.

Verification
REQ-031 W=8, add 0x5A+0x33, out_ready=1 -> in_ready drops on the accepting edge, out_valid 8 edges later, out_sum=0x8D, out_carry=0.
REQ-032 W=8, add 0xFF+0x01 -> out_sum=0x00, out_carry=1. Then 0xFF+0xFF -> out_sum=0xFE, out_carry=1.
REQ-033 W=8, SERIAL_SUB_EN, 0x10-0x20 -> out_sum=0xF0, out_carry=0. Then 0x20-0x20 -> out_sum=0x00, out_carry=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and inputs -> out_sum stable, no new accept. out_ready=1 -> IDLE next edge.
REQ-035 Assert reset asynchronously at RUN bit 3 -> out_valid=0, in_ready=1 after deassertion. The next 0x01+0x02 -> out_sum=0x03.
REQ-036 Random back-to-back operations (1000, W=32, both modes) -> every result matches a reference model, and the spacing between accepts is at least W+2 cycles.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder that reuses one full-adder cell LSB-first over W cycles.
// Define SERIAL_SUB_EN to add the in_sub port and the subtract mode.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
`ifdef SERIAL_SUB_EN
  input  logic         in_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_carry
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. in_ready is high only in IDLE, out_valid only in DONE, so there is
  // never more than one operation in flight.

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  res_sr;
  logic [CW-1:0] bit_cnt;
  logic          carry_q;
  logic          sub_q;
  logic          load;
  logic          step;
  logic          last_bit;
  logic          start_sub;
  logic          fa_b;
  logic          fa_sum;
  logic          fa_cout;

`ifdef SERIAL_SUB_EN
  assign start_sub = in_sub;
`else
  assign start_sub = 1'b0;
`endif

  assign last_bit = (bit_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: the carry flop is preset to 1 and b is inverted.
  assign fa_b = b_sr[0] ^ sub_q;

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .s    (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      bit_cnt <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else if (load) begin
      a_sr    <= in_a;
      b_sr    <= in_b;
      bit_cnt <= '0;
      carry_q <= start_sub;
      sub_q   <= start_sub;
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= {fa_sum, res_sr[W-1:1]};
      carry_q <= fa_cout;
      // Counter parks on the last index so it never wraps.
      if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign out_sum   = res_sr;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed W=8 cases on one instance and random
// W=32 traffic on another, both checked each cycle against a behavioural model.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv   [2];
  logic [63:0] ia   [2];
  logic [63:0] ib   [2];
  logic        ordy [2];
`ifdef SERIAL_SUB_EN
  logic        isub [2];
`endif

  logic        irdy8, ov8, oc8;
  logic [7:0]  os8;
  logic        irdy32, ov32, oc32;
  logic [31:0] os32;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.W(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv[0]),
    .in_ready  (irdy8),
    .in_a      (ia[0][7:0]),
    .in_b      (ib[0][7:0]),
`ifdef SERIAL_SUB_EN
    .in_sub    (isub[0]),
`endif
    .out_valid (ov8),
    .out_ready (ordy[0]),
    .out_sum   (os8),
    .out_carry (oc8)
  );

  serial_adder_ctrl #(.W(32)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv[1]),
    .in_ready  (irdy32),
    .in_a      (ia[1][31:0]),
    .in_b      (ib[1][31:0]),
`ifdef SERIAL_SUB_EN
    .in_sub    (isub[1]),
`endif
    .out_valid (ov32),
    .out_ready (ordy[1]),
    .out_sum   (os32),
    .out_carry (oc32)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_sub(input int d, input logic v);
`ifdef SERIAL_SUB_EN
    isub[d] = v;
`else
    if (v && d > 1) $display("unused sub request");
`endif
  endtask

  // ---------------- behavioural model + compare process ----------------
  // Phase 0 = accepting, 1 = busy with m_left edges still to go, 2 = result held.
  int          m_phase  [2] = '{0, 0};
  int          m_left   [2] = '{0, 0};
  logic [63:0] m_sum    [2];
  logic        m_cy     [2];
  int          last_acc [2] = '{-1, -1};
  int          dut_done [2] = '{0, 0};
  int          cyc = 0;

  always @(negedge clk) begin
    int          w;
    logic        rdy, vld, cy, sub;
    logic [63:0] sm, mask;
    logic [64:0] t;
    string       pfx;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      w    = (d == 0) ? 8 : 32;
      pfx  = (d == 0) ? "w8" : "w32";
      mask = (64'd1 << w) - 64'd1;
      if (d == 0) begin
        rdy = irdy8;  vld = ov8;  cy = oc8;  sm = {56'd0, os8};
      end else begin
        rdy = irdy32; vld = ov32; cy = oc32; sm = {32'd0, os32};
      end
      if (reset) begin
        chk({pfx, "_rst_ready"}, rdy, 1);
        chk({pfx, "_rst_valid"}, vld, 0);
        chk({pfx, "_rst_sum"},   sm,  0);
        chk({pfx, "_rst_carry"}, cy,  0);
        m_phase[d]  = 0;
        last_acc[d] = -1;
      end else begin
        chk({pfx, "_ready"}, rdy, (m_phase[d] == 0));
        chk({pfx, "_valid"}, vld, (m_phase[d] == 2));
        if (m_phase[d] == 2) begin
          chk({pfx, "_sum"},   sm, m_sum[d]);
          chk({pfx, "_carry"}, cy, m_cy[d]);
        end
        if (vld && ordy[d]) dut_done[d]++;
        if (rdy && iv[d]) begin
          if (last_acc[d] >= 0) chk({pfx, "_accept_spacing_ok"}, (cyc - last_acc[d] >= w + 2), 1);
          last_acc[d] = cyc;
        end
        case (m_phase[d])
          0: if (iv[d]) begin
            sub = 1'b0;
`ifdef SERIAL_SUB_EN
            sub = isub[d];
`endif
            if (sub) begin
              m_sum[d] = (ia[d] - ib[d]) & mask;
              m_cy[d]  = (ia[d] >= ib[d]);
            end else begin
              t        = {1'b0, ia[d]} + {1'b0, ib[d]};
              m_sum[d] = t[63:0] & mask;
              m_cy[d]  = t[w];
            end
            m_left[d]  = w;
            m_phase[d] = 1;
          end
          1: begin
            m_left[d]--;
            if (m_left[d] == 0) m_phase[d] = 2;
          end
          default: if (ordy[d]) m_phase[d] = 0;
        endcase
      end
    end
  end

  // ---------------- driver tasks (entered at posedge+1 with dut8 idle) ----------------
  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input logic [7:0] es, input logic ec);
    int n;
    iv[0] = 1'b1; ia[0] = {56'd0, a}; ib[0] = {56'd0, b}; set_sub(0, sub); ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk({name, "_ready_drop"}, irdy8, 0);
    iv[0] = 1'b0;
    ia[0] = {56'd0, 8'($urandom)};
    ib[0] = {56'd0, 8'($urandom)};
    set_sub(0, 1'($urandom_range(0, 1)));
    n = 0;
    while (!ov8 && n < 40) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, n, 8);
    chk({name, "_sum"}, os8, es);
    chk({name, "_carry"}, oc8, ec);
    @(posedge clk); #1;
    chk({name, "_back_idle"}, irdy8, 1);
  endtask

  task automatic wait_out8(input string name);
    int n;
    n = 0;
    while (!ov8 && n < 40) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, n, 8);
  endtask

  initial begin
    logic was;
    int   n;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ia[d] = '0; ib[d] = '0; ordy[d] = 1'b1; set_sub(d, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", irdy8, 1);
    chk("reset_valid", ov8, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", irdy8, 1);
    chk("post_reset_sum", os8, 0);
    chk("post_reset_carry", oc8, 0);

    op8("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
`ifdef SERIAL_SUB_EN
    op8("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0);
    op8("sub_20_20", 8'h20, 8'h20, 1'b1, 8'h00, 1'b1);
`endif

    // Result must hold while the consumer stalls, whatever the producer does.
    iv[0] = 1'b1; ia[0] = 64'h12; ib[0] = 64'h34; set_sub(0, 1'b0); ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_out8("hold");
    repeat (5) begin
      iv[0] = 1'($urandom_range(0, 1));
      ia[0] = {56'd0, 8'($urandom)};
      ib[0] = {56'd0, 8'($urandom)};
      @(posedge clk); #1;
      chk("hold_sum", os8, 8'h46);
      chk("hold_valid", ov8, 1);
      chk("hold_ready", irdy8, 0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", irdy8, 1);
    chk("release_valid", ov8, 0);

    // Asynchronous reset while bit 3 is in flight.
    iv[0] = 1'b1; ia[0] = 64'hAA; ib[0] = 64'h55;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_ready", irdy8, 1);
    chk("async_rst_valid", ov8, 0);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("after_rst_ready", irdy8, 1);
    chk("after_rst_valid", ov8, 0);
    chk("after_rst_sum", os8, 0);
    @(posedge clk); #1;
    op8("add_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Random back-to-back traffic on the W=32 instance.
    for (int k = 0; k < 1000; k++) begin
      case ($urandom_range(0, 5))
        0:       ia[1] = 64'hFFFF_FFFF;
        1:       ia[1] = 64'd0;
        default: ia[1] = {32'd0, $urandom};
      endcase
      ib[1] = ($urandom_range(0, 7) == 0) ? ia[1] : {32'd0, $urandom};
      set_sub(1, 1'($urandom_range(0, 1)));
      iv[1] = 1'b1;
      n = 0;
      do begin
        was = irdy32;
        @(posedge clk); #1;
        ordy[1] = ($urandom_range(0, 3) != 0);
        n++;
      end while (!was && n < 200);
      chk("rand_accept", was, 1);
      if ($urandom_range(0, 7) == 0) begin
        iv[1] = 1'b0;
        @(posedge clk); #1;
      end
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    n = 0;
    while (dut_done[1] < 1000 && n < 100) begin @(posedge clk); #1; n++; end
    chk("rand_results", dut_done[1], 1000);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
